pipe_skid_reg: RTL and testbench

Parametrised, handshaked pipeline stage register for the rv32i pipeline. It generalises the fixed-field, load-enabled stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) into one width-generic block. It adds a valid/ready handshake, an optional 2-entry skid buffer that registers the backpressure path, synchronous flush for branch/hazard squash, and an occupancy output. It sits between any two pipeline stages; the upstream stage packs its fields (pc, ir, alu, ctrl word, ...) into in_data.

---
 rtl/pipe_skid_reg.sv | 101 ++++++++++
 tb/tb_pipe_skid_reg.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Handshaked, width-generic pipeline stage register with optional 2-entry skid
// buffer, synchronous flush to an all-zero bubble, and an occupancy count.
module pipe_skid_reg #(
  parameter int unsigned DATA_W  = 160,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // Encoding equals the number of held entries, so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              accept;
  logic              pop;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign pop       = out_valid && out_ready;
  assign accept    = in_valid && in_ready;

  // The rst term keeps in_ready high even if reset lands while the stage is full.
  generate
    if (SKID_EN) begin : g_skid_ready
      assign in_ready = rst || (state_q != TWO);
    end else begin : g_comb_ready
      assign in_ready = rst || !out_valid || out_ready;
    end
  endgenerate

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        if (accept && pop) begin
          main_d = in_data;
        end else if (accept && SKID_EN) begin
          state_d = TWO;
          skid_d  = in_data;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Squash wins over any same-cycle accept; a same-cycle pop was already consumed.
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end
  end

  // NOTE: the payload registers are reset as well, because the zero payload is the
  // architectural bubble downstream stages decode as a nop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: one skid instance, one single-entry instance,
// each with an expected-payload queue drained by an independent output monitor.
module tb_pipe_skid_reg;

  localparam int unsigned DW = 160;
  typedef logic [DW-1:0] data_t;

  logic clk = 1'b0;
  logic rst;

  logic  flush1, in_valid1, in_ready1, out_valid1, out_ready1;
  data_t in_data1, out_data1;
  logic [1:0] occ1;

  logic  flush0, in_valid0, in_ready0, out_valid0, out_ready0;
  data_t in_data0, out_data0;
  logic [1:0] occ0;

  data_t q1[$];
  data_t q0[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.DATA_W(DW), .SKID_EN(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .occupancy(occ1)
  );

  pipe_skid_reg #(.DATA_W(DW), .SKID_EN(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .occupancy(occ0)
  );

  task automatic check(input string name, input data_t actual, input data_t expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Scoreboard monitors: every transfer on the output side pops one expected payload.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid1 === 1'b1 && out_ready1 === 1'b1) begin
      if (q1.size() == 0) check("sb1_unexpected", out_data1, '1);
      else check("sb1_data", out_data1, q1.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid0 === 1'b1 && out_ready0 === 1'b1) begin
      if (q0.size() == 0) check("sb0_unexpected", out_data0, '1);
      else check("sb0_data", out_data0, q0.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    flush1 = 1'b0; in_valid1 = 1'b1; in_data1 = data_t'(8'hAA); out_ready1 = 1'b0;
    flush0 = 1'b0; in_valid0 = 1'b1; in_data0 = data_t'(8'hAA); out_ready0 = 1'b0;

    // Reset held two cycles with a payload offered.
    step();
    mid();
    check("rst_in_ready_during", data_t'(in_ready1), data_t'(1));
    step();
    rst = 1'b0; in_valid1 = 1'b0; in_valid0 = 1'b0;
    mid();
    check("rst_out_valid", data_t'(out_valid1), data_t'(0));
    check("rst_out_data", out_data1, '0);
    check("rst_occ", data_t'(occ1), data_t'(0));
    check("rst_in_ready", data_t'(in_ready1), data_t'(1));
    check("rst_in_ready0", data_t'(in_ready0), data_t'(1));
    check("rst_occ0", data_t'(occ0), data_t'(0));

    // Streaming at full rate.
    step();
    out_ready1 = 1'b1;
    in_valid1 = 1'b1; in_data1 = data_t'(8'h01); q1.push_back(data_t'(8'h01));
    mid();
    check("stream_in_ready_0", data_t'(in_ready1), data_t'(1));
    for (int i = 2; i <= 3; i++) begin
      step();
      in_data1 = data_t'(i); q1.push_back(data_t'(i));
      mid();
      check("stream_occ", data_t'(occ1), data_t'(1));
      check("stream_in_ready", data_t'(in_ready1), data_t'(1));
    end
    step();
    in_valid1 = 1'b0;
    mid();
    check("stream_occ_last", data_t'(occ1), data_t'(1));
    check("stream_last_data", out_data1, data_t'(8'h03));
    step();
    mid();
    check("stream_drained_occ", data_t'(occ1), data_t'(0));

    // Backpressure fills main and skid; third payload is held upstream.
    step();
    out_ready1 = 1'b0;
    in_valid1 = 1'b1; in_data1 = data_t'(8'h10); q1.push_back(data_t'(8'h10));
    step();
    in_data1 = data_t'(8'h11); q1.push_back(data_t'(8'h11));
    mid();
    check("bp_occ1", data_t'(occ1), data_t'(1));
    check("bp_in_ready1", data_t'(in_ready1), data_t'(1));
    step();
    in_data1 = data_t'(8'h12); q1.push_back(data_t'(8'h12));
    mid();
    check("bp_occ2", data_t'(occ1), data_t'(2));
    check("bp_in_ready_full", data_t'(in_ready1), data_t'(0));
    check("bp_head", out_data1, data_t'(8'h10));
    step();
    mid();
    check("bp_hold_occ", data_t'(occ1), data_t'(2));
    check("bp_hold_head", out_data1, data_t'(8'h10));
    step();
    out_ready1 = 1'b1;
    step();
    mid();
    check("bp_refill_ready", data_t'(in_ready1), data_t'(1));
    step();
    in_valid1 = 1'b0;
    step();
    mid();
    check("bp_drained_occ", data_t'(occ1), data_t'(0));
    check("bp_queue_empty", data_t'(q1.size()), data_t'(0));

    // Flush with a full buffer and no input.
    step();
    out_ready1 = 1'b0;
    in_valid1 = 1'b1; in_data1 = data_t'(8'h20); q1.push_back(data_t'(8'h20));
    step();
    in_data1 = data_t'(8'h21); q1.push_back(data_t'(8'h21));
    step();
    in_valid1 = 1'b0;
    mid();
    check("fl_full_occ", data_t'(occ1), data_t'(2));
    check("fl_full_head", out_data1, data_t'(8'h20));
    step();
    flush1 = 1'b1;
    step();
    flush1 = 1'b0;
    q1.delete();
    mid();
    check("fl_out_valid", data_t'(out_valid1), data_t'(0));
    check("fl_out_data", out_data1, '0);
    check("fl_occ", data_t'(occ1), data_t'(0));
    check("fl_in_ready", data_t'(in_ready1), data_t'(1));

    // Flush with a same-cycle input: the held entry is consumed, 0x30 is dropped.
    step();
    out_ready1 = 1'b1;
    in_valid1 = 1'b1; in_data1 = data_t'(8'h2F); q1.push_back(data_t'(8'h2F));
    step();
    flush1 = 1'b1; in_data1 = data_t'(8'h30);
    mid();
    check("fl2_in_ready", data_t'(in_ready1), data_t'(1));
    step();
    flush1 = 1'b0; in_valid1 = 1'b0;
    mid();
    check("fl2_occ", data_t'(occ1), data_t'(0));
    check("fl2_out_valid", data_t'(out_valid1), data_t'(0));
    check("fl2_out_data", out_data1, '0);
    repeat (3) step();
    mid();
    check("fl2_queue_empty", data_t'(q1.size()), data_t'(0));

    // Single-entry mode: combinational ready follows out_ready.
    step();
    in_valid0 = 1'b1; in_data0 = data_t'(8'h40); q0.push_back(data_t'(8'h40));
    mid();
    check("ne_in_ready_empty", data_t'(in_ready0), data_t'(1));
    step();
    in_valid0 = 1'b0;
    mid();
    check("ne_in_ready_blocked", data_t'(in_ready0), data_t'(0));
    check("ne_head", out_data0, data_t'(8'h40));
    check("ne_occ_one", data_t'(occ0), data_t'(1));
    step();
    in_valid0 = 1'b1; in_data0 = data_t'(8'h3F);
    mid();
    check("ne_ooc_ready", data_t'(in_ready0), data_t'(0));
    step();
    mid();
    check("ne_ooc_occ", data_t'(occ0), data_t'(1));
    check("ne_ooc_head", out_data0, data_t'(8'h40));
    step();
    out_ready0 = 1'b1;
    in_data0 = data_t'(8'h41); q0.push_back(data_t'(8'h41));
    mid();
    check("ne_in_ready_pop", data_t'(in_ready0), data_t'(1));
    step();
    in_valid0 = 1'b0; out_ready0 = 1'b0;
    mid();
    check("ne_head_41", out_data0, data_t'(8'h41));
    check("ne_occ_41", data_t'(occ0), data_t'(1));
    step();
    out_ready0 = 1'b1;
    step();
    mid();
    check("ne_drained_occ", data_t'(occ0), data_t'(0));
    check("ne_queue_empty", data_t'(q0.size()), data_t'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
